// File: rtl/tile_psum_drain.sv
// ---------------------------------------------------------------------------
// tile_psum_drain
//
// Collects the tile array's flat multiply-result bus into a signed
// partial-sum buffer, one element-wise add per capture pulse, across the
// K-dimension passes. A capture flagged as the last pass switches the block
// into DRAIN, where the buffer is streamed out ROWS elements per beat over a
// valid/ready interface. The transfer of the final beat clears the buffer and
// returns the block to IDLE, ready for the next tile.
//
// Optional build macro:
//   TILE_PSUM_DRAIN_RELU_EN - clamp negative elements to zero on o_data only;
//                             the buffer itself keeps the raw signed sums.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   i_capture    one-cycle pulse: add i_mul_result into the buffer
//   i_last       with i_capture: final pass, start draining afterwards
//   i_mul_result element e at [e*M_BW +: M_BW], two's complement
//   o_busy       high whenever the block is not IDLE
//   o_valid      output beat valid
//   i_ready      downstream accepts the current beat
//   o_data       beat element j at [j*ACC_BW +: ACC_BW]
//   o_beat_idx   index of the current beat
//   o_last       high with the final beat
//   o_err        sticky: a capture arrived while busy
// ---------------------------------------------------------------------------
module tile_psum_drain #(
  parameter int M_BW   = 16,
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int T_ROWS = 5,
  parameter int ACC_BW = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_capture,
  input  logic                                  i_last,
  input  logic [M_BW*COLS*ROWS*T_ROWS-1:0]      i_mul_result,
  output logic                                  o_busy,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [ACC_BW*ROWS-1:0]                o_data,
  output logic [$clog2(COLS*T_ROWS)-1:0]        o_beat_idx,
  output logic                                  o_last,
  output logic                                  o_err
);

  localparam int NB   = COLS*T_ROWS;
  localparam int BI_W = $clog2(COLS*T_ROWS);
  localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(NB-1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_r;
  logic [BI_W-1:0]   beat_r;
  logic              valid_r;
  logic              last_r;
  logic              err_r;
  // Buffer organised as [beat][element within beat]; flat element e = b*ROWS+j.
  logic [ACC_BW-1:0] acc_r [NB][ROWS];

  logic [ACC_BW*ROWS-1:0] data_s;
  logic [ACC_BW-1:0]      sel_s;

  // Sign-extend one input element to accumulator width.
  function automatic logic [ACC_BW-1:0] sext(input logic [M_BW-1:0] v);
    sext = ACC_BW'($signed(v));
  endfunction

  // Control FSM plus partial-sum buffer: accumulate in IDLE, stream in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      beat_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      err_r   <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        for (int j = 0; j < ROWS; j++) begin
          acc_r[b][j] <= '0;
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (i_capture) begin
            for (int b = 0; b < NB; b++) begin
              for (int j = 0; j < ROWS; j++) begin
                acc_r[b][j] <= acc_r[b][j] + sext(i_mul_result[(b*ROWS+j)*M_BW +: M_BW]);
              end
            end
            if (i_last) begin
              state_r <= DRAIN;
              beat_r  <= '0;
              valid_r <= 1'b1;
              last_r  <= (LAST_BEAT == '0);
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          // Any capture while draining is dropped; flag it permanently.
          if (i_capture) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
          if (i_ready) begin
            if (beat_r == LAST_BEAT) begin
              state_r <= IDLE;
              beat_r  <= '0;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              for (int b = 0; b < NB; b++) begin
                for (int j = 0; j < ROWS; j++) begin
                  acc_r[b][j] <= '0;
                end
              end
            end else begin
              beat_r <= beat_r + BI_W'(1);
              last_r <= ((beat_r + BI_W'(1)) == LAST_BEAT);
            end
          end else begin
            beat_r <= beat_r;
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= '0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Select the current beat's elements from the registered buffer.
  always_comb begin
    data_s = '0;
    sel_s  = '0;
    for (int j = 0; j < ROWS; j++) begin
      sel_s = acc_r[beat_r][j];
`ifdef TILE_PSUM_DRAIN_RELU_EN
      if (sel_s[ACC_BW-1]) begin
        data_s[j*ACC_BW +: ACC_BW] = '0;
      end else begin
        data_s[j*ACC_BW +: ACC_BW] = sel_s;
      end
`else
      data_s[j*ACC_BW +: ACC_BW] = sel_s;
`endif
    end
  end

  assign o_busy     = (state_r != IDLE);
  assign o_valid    = valid_r;
  assign o_data     = data_s;
  assign o_beat_idx = beat_r;
  assign o_last     = last_r;
  assign o_err      = err_r;

endmodule

// File: tb/tb_tile_psum_drain.sv
// Self-checking bench for tile_psum_drain: a sum-per-element model computed
// with plain integers predicts every drained beat.
module tb_tile_psum_drain;

  localparam int M_BW   = 16;
  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int T_ROWS = 5;
  localparam int ACC_BW = 24;
  localparam int NE     = COLS*ROWS*T_ROWS;
  localparam int NB     = COLS*T_ROWS;
  localparam int IN_W   = M_BW*NE;
  localparam int BI_W   = $clog2(NB);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_capture;
  logic                   i_last;
  logic [IN_W-1:0]        i_mul_result;
  logic                   o_busy;
  logic                   o_valid;
  logic                   i_ready;
  logic [ACC_BW*ROWS-1:0] o_data;
  logic [BI_W-1:0]        o_beat_idx;
  logic                   o_last;
  logic                   o_err;

  tile_psum_drain #(
    .M_BW(M_BW), .ROWS(ROWS), .COLS(COLS), .T_ROWS(T_ROWS), .ACC_BW(ACC_BW)
  ) dut (
    .clk(clk), .rst(rst), .i_capture(i_capture), .i_last(i_last),
    .i_mul_result(i_mul_result), .o_busy(o_busy), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_beat_idx(o_beat_idx),
    .o_last(o_last), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Unbounded per-element sums; truncation to ACC_BW happens on prediction.
  longint model_sum [NE];

  logic [ACC_BW*ROWS-1:0] got_data [NB];
  logic [BI_W-1:0]        got_idx  [NB];
  logic                   got_last [NB];
  int                     n_xfer;
  int                     stall_changes;
  int                     cycles;
  bit                     timed_out;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] fill(input logic [M_BW-1:0] v);
    logic [IN_W-1:0] r;
    for (int e = 0; e < NE; e++) r[e*M_BW +: M_BW] = v;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] r;
    for (int e = 0; e < NE; e++) r[e*M_BW +: M_BW] = M_BW'($urandom);
    return r;
  endfunction

  task automatic model_clear;
    for (int e = 0; e < NE; e++) model_sum[e] = 0;
  endtask

  // Issue one capture pulse from IDLE and fold it into the model.
  task automatic capture(input logic [IN_W-1:0] v, input logic last);
    i_mul_result = v;
    i_last       = last;
    i_capture    = 1'b1;
    step;
    i_capture    = 1'b0;
    i_last       = 1'b0;
    for (int e = 0; e < NE; e++) model_sum[e] += longint'($signed(v[e*M_BW +: M_BW]));
  endtask

  function automatic logic [ACC_BW*ROWS-1:0] exp_beat(input int b);
    logic [ACC_BW*ROWS-1:0] r;
    logic [ACC_BW-1:0] w;
    r = '0;
    for (int j = 0; j < ROWS; j++) begin
      w = ACC_BW'(model_sum[b*ROWS+j]);
`ifdef TILE_PSUM_DRAIN_RELU_EN
      if ($signed(w) < 0) w = '0;
`endif
      r[j*ACC_BW +: ACC_BW] = w;
    end
    return r;
  endfunction

  // Drive i_ready (0: always, 1: 1,0,0,1 repeating, 2: random) and record
  // every accepted beat; optionally pulse a capture when beat inj_beat shows.
  task automatic collect(input int mode, input int inj_beat, input int budget);
    logic [ACC_BW*ROWS-1:0] snap_d;
    logic [BI_W-1:0]        snap_i;
    bit have_snap, done, injected;
    n_xfer = 0; stall_changes = 0; cycles = 0;
    have_snap = 0; done = 0; injected = 0;
    snap_d = '0; snap_i = '0;
    for (int b = 0; b < NB; b++) begin
      got_data[b] = '0; got_idx[b] = '0; got_last[b] = 1'b0;
    end
    for (int c = 0; c < budget && !done; c++) begin
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      if (inj_beat >= 0 && !injected && o_valid === 1'b1 && int'(o_beat_idx) == inj_beat) begin
        i_mul_result = rand_vec();
        i_last       = 1'b1;
        i_capture    = 1'b1;
        injected     = 1;
      end
      #1;
      if (have_snap) begin
        if (o_data !== snap_d || o_beat_idx !== snap_i) stall_changes++;
        have_snap = 0;
      end
      if (o_valid === 1'b1) begin
        if (i_ready) begin
          if (n_xfer < NB) begin
            got_data[n_xfer] = o_data;
            got_idx[n_xfer]  = o_beat_idx;
            got_last[n_xfer] = o_last;
          end
          n_xfer++;
          if (o_last === 1'b1) done = 1;
        end else begin
          snap_d = o_data; snap_i = o_beat_idx; have_snap = 1;
        end
      end
      step;
      cycles++;
      i_capture = 1'b0;
      i_last    = 1'b0;
    end
    timed_out = !done;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_capture = 1'b0; i_last = 1'b0; i_ready = 1'b0; i_mul_result = '0;
    step; step; step;
    rst = 1'b0;
    model_clear();
    n_checks++;
    if ({o_valid, o_last, o_busy, o_err} !== 4'b0000 || o_beat_idx !== '0) begin
      n_fail++;
      $display("FAIL reset: valid=%b last=%b busy=%b err=%b idx=%0d, want all 0",
               o_valid, o_last, o_busy, o_err, o_beat_idx);
    end
  endtask

  task automatic test_uniform;
    capture(fill(16'h0003), 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL uniform_latency: valid=%b busy=%b, want 1 1", o_valid, o_busy);
    end
    collect(0, -1, 60);
    n_checks++;
    if (timed_out || n_xfer != NB || cycles != NB) begin
      n_fail++; $display("FAIL uniform_count: xfers=%0d cycles=%0d timeout=%0d, want %0d %0d 0",
                         n_xfer, cycles, timed_out, NB, NB);
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL uniform_idle_after: busy=%b valid=%b, want 0 0", o_busy, o_valid);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (got_data[b] !== exp_beat(b) || got_idx[b] !== BI_W'(b) || got_last[b] !== (b == NB-1)) begin
        n_fail++; $display("FAIL uniform_beat %0d: idx=%0d last=%b data=%h, want idx=%0d data=%h",
                           b, got_idx[b], got_last[b], got_data[b], b, exp_beat(b));
      end
    end
    n_checks++;
    if (got_data[3][2*ACC_BW +: ACC_BW] !== 24'h000003) begin
      n_fail++; $display("FAIL uniform_const: got %h want 000003", got_data[3][2*ACC_BW +: ACC_BW]);
    end
    model_clear();
  endtask

  task automatic test_ramp_accum;
    logic [IN_W-1:0] v;
    for (int e = 0; e < NE; e++) v[e*M_BW +: M_BW] = M_BW'(e);
    capture(v, 1'b0); step;
    capture(v, 1'b0);
    capture(v, 1'b1);
    collect(0, -1, 60);
    n_checks++;
    if (timed_out || n_xfer != NB) begin
      n_fail++; $display("FAIL ramp_count: xfers=%0d timeout=%0d, want %0d 0", n_xfer, timed_out, NB);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (got_data[b] !== exp_beat(b) || got_idx[b] !== BI_W'(b)) begin
        n_fail++; $display("FAIL ramp_beat %0d: idx=%0d data=%h, want data=%h",
                           b, got_idx[b], got_data[b], exp_beat(b));
      end
    end
    n_checks++;
    if (got_data[24][4*ACC_BW +: ACC_BW] !== 24'd372) begin
      n_fail++; $display("FAIL ramp_const: got %0d want 372", got_data[24][4*ACC_BW +: ACC_BW]);
    end
    model_clear();
  endtask

  task automatic test_negative;
    logic [ACC_BW-1:0] want;
`ifdef TILE_PSUM_DRAIN_RELU_EN
    want = 24'h000000;
`else
    want = 24'hFF8000;
`endif
    capture(fill(16'h8000), 1'b1);
    collect(0, -1, 60);
    n_checks++;
    if (timed_out || n_xfer != NB) begin
      n_fail++; $display("FAIL neg_count: xfers=%0d timeout=%0d, want %0d 0", n_xfer, timed_out, NB);
    end
    for (int b = 0; b < NB; b += 6) begin
      n_checks++;
      if (got_data[b] !== {ROWS{want}}) begin
        n_fail++; $display("FAIL neg_beat %0d: data=%h, want %h repeated", b, got_data[b], want);
      end
    end
    model_clear();
  endtask

  task automatic test_stall;
    capture(rand_vec(), 1'b1);
    collect(1, -1, 200);
    n_checks++;
    if (timed_out || n_xfer != NB || stall_changes != 0) begin
      n_fail++; $display("FAIL stall_count: xfers=%0d stall_changes=%0d timeout=%0d, want %0d 0 0",
                         n_xfer, stall_changes, timed_out, NB);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (got_data[b] !== exp_beat(b) || got_idx[b] !== BI_W'(b) || got_last[b] !== (b == NB-1)) begin
        n_fail++; $display("FAIL stall_beat %0d: idx=%0d last=%b data=%h, want data=%h",
                           b, got_idx[b], got_last[b], got_data[b], exp_beat(b));
      end
    end
    model_clear();
  endtask

  task automatic test_random;
    int k;
    for (int p = 0; p < 3; p++) begin
      // i_last without i_capture must not start a drain.
      i_last = 1'b1; step; i_last = 1'b0;
      n_checks++;
      if (o_busy !== 1'b0) begin
        n_fail++; $display("FAIL rand_last_alone: busy=%b want 0", o_busy);
      end
      k = $urandom_range(1, 3);
      for (int c = 0; c < k; c++) begin
        capture(rand_vec(), (c == k-1));
        if ($urandom_range(0, 1) == 1 && c != k-1) step;
      end
      collect(2, -1, 400);
      n_checks++;
      if (timed_out || n_xfer != NB || stall_changes != 0) begin
        n_fail++; $display("FAIL rand_count pass %0d: xfers=%0d stall_changes=%0d timeout=%0d",
                           p, n_xfer, stall_changes, timed_out);
      end
      for (int b = 0; b < NB; b++) begin
        n_checks++;
        if (got_data[b] !== exp_beat(b) || got_idx[b] !== BI_W'(b)) begin
          n_fail++; $display("FAIL rand_beat %0d pass %0d: data=%h, want %h",
                             b, p, got_data[b], exp_beat(b));
        end
      end
      model_clear();
    end
  endtask

  task automatic test_capture_during_drain;
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clean: err=%b want 0", o_err);
    end
    capture(fill(16'h0002), 1'b1);
    collect(2, 10, 400);
    n_checks++;
    if (o_err !== 1'b1 || timed_out || n_xfer != NB) begin
      n_fail++; $display("FAIL err_set: err=%b xfers=%0d timeout=%0d, want 1 %0d 0",
                         o_err, n_xfer, timed_out, NB);
    end
    for (int b = 0; b < NB; b += 4) begin
      n_checks++;
      if (got_data[b] !== exp_beat(b)) begin
        n_fail++; $display("FAIL err_data beat %0d: data=%h want %h", b, got_data[b], exp_beat(b));
      end
    end
    model_clear();
    // Next pass starts from zero; a capture on the final transfer is dropped.
    capture(fill(16'h0001), 1'b1);
    collect(0, NB-1, 60);
    n_checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b1 || got_data[NB-1] !== {ROWS{24'h000001}}) begin
      n_fail++; $display("FAIL err_final_beat: busy=%b err=%b data=%h, want 0 1 all-1",
                         o_busy, o_err, got_data[NB-1]);
    end
    model_clear();
    capture(fill(16'h0004), 1'b1);
    collect(0, -1, 60);
    n_checks++;
    if (timed_out || got_data[0] !== exp_beat(0) || got_data[NB-1] !== exp_beat(NB-1)) begin
      n_fail++; $display("FAIL err_after_final: data0=%h want %h", got_data[0], exp_beat(0));
    end
    model_clear();
  endtask

  task automatic test_reset_mid_drain;
    bit found;
    capture(rand_vec(), 1'b1);
    i_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (o_valid === 1'b1 && o_beat_idx === BI_W'(7)) found = 1;
      else step;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rstmid_reach: beat 7 not seen, idx=%0d", o_beat_idx);
    end
    rst = 1'b1; step; rst = 1'b0;
    model_clear();
    n_checks++;
    if ({o_valid, o_busy, o_err, o_last} !== 4'b0000 || o_beat_idx !== '0) begin
      n_fail++; $display("FAIL rstmid_state: valid=%b busy=%b err=%b last=%b idx=%0d, want 0",
                         o_valid, o_busy, o_err, o_last, o_beat_idx);
    end
    capture(fill(16'h0005), 1'b1);
    collect(0, -1, 60);
    n_checks++;
    if (timed_out || n_xfer != NB) begin
      n_fail++; $display("FAIL rstmid_count: xfers=%0d timeout=%0d", n_xfer, timed_out);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (got_data[b] !== {ROWS{24'h000005}}) begin
        n_fail++; $display("FAIL rstmid_beat %0d: data=%h want all 000005", b, got_data[b]);
      end
    end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_ramp_accum();
    test_negative();
    test_stall();
    test_random();
    test_capture_during_drain();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_psum_drain.md
Name: tile_psum_drain

Overview:
- Downstream consumer of the tile array's flat multiply-result bus.
- Accumulates one or more result vectors element-wise into a signed partial-sum buffer, one vector per capture, across K-dimension passes.
- On the last pass, streams the buffer out as fixed-width beats over a valid/ready interface toward the output feature-map writer.
- Clears itself after each completed drain.

Parameters:
- M_BW, 16, bit width of one signed result element on the input bus
- ROWS, 5, PE rows per tile; elements per output beat
- COLS, 5, PE columns per tile
- T_ROWS, 5, tile rows in the array
- ACC_BW, 24, signed accumulator width per element (must be >= M_BW)
- Derived: NE = COLS*ROWS*T_ROWS elements (125); NB = COLS*T_ROWS beats (25); IN_W = M_BW*NE

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_capture  in  1  one-cycle pulse: accumulate i_mul_result into the buffer
- i_last  in  1  qualifies i_capture: this is the final pass, drain afterwards
- i_mul_result  in  IN_W  element e at bits [e*M_BW +: M_BW], two's complement
- o_busy  out  1  high whenever state != IDLE
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the beat
- o_data  out  ACC_BW*ROWS  beat element j at bits [j*ACC_BW +: ACC_BW]
- o_beat_idx  out  $clog2(NB)  index of the current beat
- o_last  out  1  high with the final beat (index NB-1)
- o_err  out  1  sticky: capture arrived while busy

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, all buffer elements 0, o_valid=0, o_last=0, o_beat_idx=0, o_err=0, o_busy=0.
- States: IDLE, DRAIN.
- IDLE + i_capture:
  - Every element updates as buf[e] <= buf[e] + sext(i_mul_result elem e) at the same edge.
  - Arithmetic is signed and wraps modulo 2^ACC_BW; there is no saturation.
  - If i_last=1, go to DRAIN with beat=0; otherwise stay in IDLE.
- IDLE without i_capture: hold. i_last is ignored unless i_capture=1.
- Latency: a capture with i_last at edge t gives o_valid=1 from cycle t+1.
- DRAIN:
  - o_valid=1.
  - o_data = buf[beat*ROWS + j] for j=0..ROWS-1.
  - o_beat_idx = beat; o_last = (beat==NB-1).
- Handshake:
  - A beat transfers on o_valid && i_ready.
  - o_data, o_beat_idx and o_last stay stable while o_valid && !i_ready.
  - Back-to-back transfers are allowed: one beat per cycle with i_ready held high.
- Final beat transfer (beat NB-1 accepted):
  - Same edge: all buffer elements clear to 0, state goes to IDLE, o_valid=0.
  - Minimum drain time is NB cycles.
- i_capture while in DRAIN:
  - Ignored: the buffer is not modified.
  - o_err is set and stays set until rst.
- i_capture in the same cycle as the final-beat transfer:
  - Treated as busy: ignored, o_err is set.
  - The next pass must be issued while o_busy=0.
- Reset mid-drain: next edge gives IDLE, buffer 0, o_valid 0. No partial beats remain.
- i_ready is don't-care when o_valid=0.
- o_busy is combinational from state; all other outputs are registered or derived from registered state.

Optional Feature:
- Macro: TILE_PSUM_DRAIN_RELU_EN
- Defined: each o_data element is clamped to 0 when its buffer value is negative. Only the streamed output is affected; buffer contents and accumulation are unchanged.
- Undefined: o_data carries the raw signed buffer values.

Test Plan:
- Reset, then one capture with i_last=1, every element = 16'h0003, i_ready=1 -> 25 consecutive beats, each element 24'h000003; o_last only on beat 24; o_busy low the cycle after beat 24.
- Three captures of element e = e (signed), the third with i_last=1 -> beat b element j = 3*(b*5+j); e.g. beat 24 element 4 = 372.
- Capture all elements = 16'h8000 (-32768) with i_last=1 ->
  - macro off: elements 24'hFF8000;
  - macro on: elements 0.
- Drain with i_ready toggling 1,0,0,1 per cycle -> no beat dropped or duplicated; o_data and o_beat_idx held during stalls; 25 transfers total.
- i_capture pulsed at beat 10 of a drain -> o_err=1 and stays 1; drained data is unchanged. A following pass after drain starts from a zero buffer: capture 1 with i_last gives all elements 1.
- rst asserted at beat 7 of a drain -> o_valid=0 next cycle. A subsequent capture of value 5 with i_last drains 5s, not 5 plus the old values.
